apb_initiator: RTL and testbench
================================

APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum number of ACCESS cycles with PREADY=0 before the transfer is aborted (legal range 1..255).
REQ-002 SHALL have port PCLK  input  1  the single clock; every register is clocked on its rising edge.
REQ-003 SHALL have port PRESETn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid  input  1  the requester presents a command.
REQ-005 SHALL have port cmd_ready  output  1  the block accepts a command; high only in IDLE.
REQ-006 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_addr  input  18  word address bits [19:2].
REQ-008 SHALL have port cmd_wdata  input  32  write data.
REQ-009 SHALL have port rsp_valid  output  1  a response is available.
REQ-010 SHALL have port rsp_ready  input  1  the requester consumes the response.
REQ-011 SHALL have port rsp_rdata  output  32  read data.
REQ-012 SHALL have port rsp_err  output  1  PSLVERR was sampled or a timeout occurred.
REQ-013 SHALL have port rsp_timeout  output  1  the transfer was aborted by timeout.
REQ-014 SHALL have ports PSEL, PENABLE and PWRITE  output  1 each  APB controls.
REQ-015 SHALL have ports PADDR  output  18, as bits [19:2], and PWDATA  output  32.
REQ-016 SHALL have ports PRDATA  input  32, PREADY  input  1 and PSLVERR  input  1.

Function
REQ-017 SHALL implement a four-state FSM with states IDLE, SETUP, ACCESS and RESP.
REQ-018 IDLE: cmd_ready=1; on cmd_valid&cmd_ready, SHALL register cmd_write, cmd_addr and cmd_wdata and move to SETUP on the next edge.
REQ-019 SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then SHALL move to ACCESS.
REQ-020 ACCESS: PSEL=1, PENABLE=1; SHALL hold until PREADY=1 or timeout.
REQ-021 PADDR, PWRITE and PWDATA SHALL stay stable from SETUP through the end of ACCESS, and SHALL hold their last values in IDLE and RESP.
REQ-022 Completion is ACCESS with PREADY=1, and SHALL produce:
- rsp_rdata = PRDATA for reads, 0 for writes;
- rsp_err = PSLVERR;
- rsp_timeout = 0;
- PSEL and PENABLE low on the next cycle, with the FSM in RESP.
REQ-023 A wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with PREADY=0.
REQ-024 When the wait count equals TIMEOUT and PREADY=0, the block SHALL abort: PSEL=0, PENABLE=0, rsp_err=1, rsp_timeout=1, rsp_rdata=32'hDEADBEEF, and the FSM moves to RESP.
REQ-025 A PREADY=1 in the same cycle the timeout is reached SHALL win: normal completion, no timeout.
REQ-026 RESP: rsp_valid=1 and the response fields SHALL stay stable until rsp_valid&rsp_ready, then the FSM moves to IDLE.
REQ-027 cmd_ready SHALL be 0 in SETUP, ACCESS and RESP.
REQ-028 A new command SHALL NOT be accepted in the cycle the response is consumed.
REQ-029 Minimum transfer latency SHALL be: accept at cycle N; SETUP at N+1; ACCESS at N+2; rsp_valid at N+3 when PREADY=1 on the first ACCESS cycle.
REQ-030 PSEL=1 with PENABLE=1 SHALL never occur outside ACCESS.
REQ-031 PENABLE SHALL never be 1 while PSEL=0.
REQ-032 PREADY, PRDATA and PSLVERR SHALL be ignored outside ACCESS.

Reset
REQ-033 PRESETn low SHALL immediately force the FSM to IDLE and clear the wait counter.
REQ-034 PRESETn low SHALL force these outputs to 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout.
REQ-035 cmd_ready SHALL be 1 in the first cycle after PRESETn deasserts.
REQ-036 Reset during SETUP, ACCESS or RESP SHALL abandon the transfer with no response generated.

Verification
REQ-037 Bench SHALL cover a read with no wait: cmd addr=18'h1, PREADY=1 and PRDATA=32'h12345678 on the first ACCESS cycle -> rsp_valid at cycle N+3, rsp_rdata=32'h12345678, rsp_err=0.
REQ-038 Bench SHALL cover a write with 3 wait states: cmd_write=1, addr=18'h5, wdata=1, PREADY low for 3 cycles -> PADDR and PWDATA stable for all 4 ACCESS cycles, rsp_rdata=0, rsp_err=0.
REQ-039 Bench SHALL cover a slave error: PSLVERR=1 with PREADY=1 -> rsp_err=1, rsp_timeout=0.
REQ-040 Bench SHALL cover a timeout: TIMEOUT=4, PREADY held 0 -> abort after 4 waiting ACCESS cycles, rsp_rdata=32'hDEADBEEF, rsp_err=1, rsp_timeout=1.
REQ-041 Bench SHALL cover response backpressure: rsp_ready held 0 for 5 cycles -> response stable and cmd_ready=0 throughout; IDLE on the cycle after the handshake.
REQ-042 Bench SHALL cover mid-ACCESS reset: assert PRESETn low -> PSEL=0 and PENABLE=0 immediately, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/apb_initiator.sv
// APB initiator: turns single command/response handshakes into APB transfers,
// aborting any transfer whose slave keeps PREADY low for more than TIMEOUT cycles.
module apb_initiator #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [17:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [17:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic       accept;
    logic       done;
    logic       timed_out;

    assign accept    = (state == IDLE) && cmd_valid;
    assign done      = (state == ACCESS) && PREADY;
    assign timed_out = (state == ACCESS) && !PREADY && (wait_cnt == TIMEOUT_CNT);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cmd_valid) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (done || timed_out) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // SETUP always precedes ACCESS, so clearing there gives a fresh count on entry.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !PREADY && !timed_out) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PWRITE <= 1'b0;
            PADDR  <= '0;
            PWDATA <= '0;
        end else if (accept) begin
            PWRITE <= cmd_write;
            PADDR  <= cmd_addr;
            PWDATA <= cmd_wdata;
        end
    end

    // A ready slave wins over a timeout that lands in the same cycle.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else if (done) begin
            rsp_rdata   <= PWRITE ? 32'h0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
        end else if (timed_out) begin
            rsp_rdata   <= 32'hDEADBEEF;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
        end
    end

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign PSEL      = (state == SETUP) || (state == ACCESS);
    assign PENABLE   = (state == ACCESS);

endmodule

// File: tb/tb_apb_initiator.sv
// Randomized bench for apb_initiator: a timeline model predicts every cycle of
// each transfer from the command, the slave's wait count and the timeout rule.
module tb_apb_initiator;

    localparam int TIMEOUT = 4;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [17:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [17:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int total = 0;
    int bad   = 0;

    apb_initiator #(.TIMEOUT(TIMEOUT)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic randomizeSlave();
        PREADY  = 1'($urandom);
        PRDATA  = $urandom;
        PSLVERR = 1'($urandom);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic applyStimulus(input logic wr, input logic [17:0] addr, input logic [31:0] wdata,
                                 input int waits, input logic [31:0] rdata, input logic slverr,
                                 input int hold);
        int          access_cycles;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        if (waits > TIMEOUT) begin
            access_cycles = TIMEOUT + 1;
            exp_rdata     = 32'hDEADBEEF;
            exp_err       = 1'b1;
            exp_to        = 1'b1;
        end else begin
            access_cycles = waits + 1;
            exp_rdata     = wr ? 32'h0 : rdata;
            exp_err       = slverr;
            exp_to        = 1'b0;
        end

        checkOutput("idle_cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        randomizeSlave();

        @(negedge PCLK);
        cmd_write = 1'($urandom);
        cmd_addr  = 18'($urandom);
        cmd_wdata = $urandom;
        randomizeSlave();
        checkOutput("setup_psel", PSEL, 1);
        checkOutput("setup_penable", PENABLE, 0);
        checkOutput("setup_cmd_ready", cmd_ready, 0);
        checkOutput("setup_rsp_valid", rsp_valid, 0);
        checkOutput("setup_paddr", PADDR, addr);
        checkOutput("setup_pwrite", PWRITE, wr);
        checkOutput("setup_pwdata", PWDATA, wdata);

        for (int k = 0; k < access_cycles; k++) begin
            @(negedge PCLK);
            checkOutput("access_psel", PSEL, 1);
            checkOutput("access_penable", PENABLE, 1);
            checkOutput("access_paddr", PADDR, addr);
            checkOutput("access_pwrite", PWRITE, wr);
            checkOutput("access_pwdata", PWDATA, wdata);
            checkOutput("access_cmd_ready", cmd_ready, 0);
            checkOutput("access_rsp_valid", rsp_valid, 0);
            if (k == waits) begin
                PREADY  = 1'b1;
                PRDATA  = rdata;
                PSLVERR = slverr;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom);
            end
        end

        for (int h = 0; h <= hold; h++) begin
            @(negedge PCLK);
            randomizeSlave();
            checkOutput("resp_valid", rsp_valid, 1);
            checkOutput("resp_rdata", rsp_rdata, exp_rdata);
            checkOutput("resp_err", rsp_err, exp_err);
            checkOutput("resp_timeout", rsp_timeout, exp_to);
            checkOutput("resp_psel", PSEL, 0);
            checkOutput("resp_penable", PENABLE, 0);
            checkOutput("resp_cmd_ready", cmd_ready, 0);
            checkOutput("resp_paddr_hold", PADDR, addr);
            rsp_ready = (h == hold);
        end

        @(negedge PCLK);
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        checkOutput("back_cmd_ready", cmd_ready, 1);
        checkOutput("back_rsp_valid", rsp_valid, 0);
        checkOutput("back_psel", PSEL, 0);
        checkOutput("back_penable", PENABLE, 0);
        checkOutput("back_paddr_hold", PADDR, addr);
        checkOutput("back_pwdata_hold", PWDATA, wdata);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_psel"}, PSEL, 0);
        checkOutput({tag, "_penable"}, PENABLE, 0);
        checkOutput({tag, "_pwrite"}, PWRITE, 0);
        checkOutput({tag, "_paddr"}, PADDR, 0);
        checkOutput({tag, "_pwdata"}, PWDATA, 0);
        checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
        checkOutput({tag, "_rsp_rdata"}, rsp_rdata, 0);
        checkOutput({tag, "_rsp_err"}, rsp_err, 0);
        checkOutput({tag, "_rsp_timeout"}, rsp_timeout, 0);
        checkOutput({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    task automatic resetInAccess(input logic [17:0] addr, input logic [31:0] wdata);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        checkOutput("pre_reset_penable", PENABLE, 1);
        #2 PRESETn = 1'b0;
        #1 checkResetOutputs("mid_reset");
        @(negedge PCLK);
        PRESETn = 1'b1;
        checkOutput("release_cmd_ready", cmd_ready, 1);
        @(negedge PCLK);
        checkOutput("after_reset_cmd_ready", cmd_ready, 1);
        checkOutput("after_reset_rsp_valid", rsp_valid, 0);
        checkOutput("after_reset_psel", PSEL, 0);
    endtask

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        #12;
        checkResetOutputs("reset");
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        checkOutput("first_cmd_ready", cmd_ready, 1);

        applyStimulus(1'b0, 18'h1, 32'h0, 0, 32'h12345678, 1'b0, 0);
        applyStimulus(1'b1, 18'h5, 32'h1, 3, 32'hCAFEF00D, 1'b0, 0);
        applyStimulus(1'b0, 18'h2A, 32'h0, 1, 32'h55AA55AA, 1'b1, 0);
        applyStimulus(1'b0, 18'h3FFFF, 32'h0, 20, 32'h11111111, 1'b0, 0);
        applyStimulus(1'b1, 18'h100, 32'hA5A5A5A5, 5, 32'h22222222, 1'b0, 1);
        applyStimulus(1'b0, 18'h7, 32'h0, TIMEOUT, 32'h0BADF00D, 1'b0, 0);
        applyStimulus(1'b1, 18'h9, 32'hFFFFFFFF, TIMEOUT, 32'h33333333, 1'b1, 0);
        applyStimulus(1'b0, 18'h123, 32'h0, 2, 32'h87654321, 1'b0, 5);

        resetInAccess(18'h2BCD, 32'h13572468);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'($urandom), 18'($urandom), $urandom, int'($urandom_range(0, 6)),
                          $urandom, 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
